// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - minute tick, hour/minute set mode, load strobe and blink flags for a BCD clock
// Outputs are registered from next-state values so they line up with the state register.
module clock_set_ctrl #(
  parameter int TICKS_PER_MIN = 60,
  parameter int BLINK_DIV     = 25,
  parameter int TIMEOUT       = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic       tick,
  output logic       load,
  output logic [3:0] ld_h1,
  output logic [3:0] ld_h0,
  output logic [3:0] ld_m1,
  output logic [3:0] ld_m0,
  output logic       blank_hr,
  output logic       blank_min,
  output logic       setting
);

  localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MIN - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_RUN, ST_SET_HR, ST_SET_MIN, ST_COMMIT} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_mode_prev, r_inc_prev;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [BW-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic          r_phase, w_phase_nxt;
  logic [IW-1:0] r_idle, w_idle_nxt;
  logic [15:0]   r_edit, w_edit_nxt;
  logic          w_tick_nxt;
  logic          w_mode_edge, w_inc_edge;

  function automatic logic [7:0] hr_inc(input logic [3:0] h1, input logic [3:0] h0);
    if (h1 >= 4'd2 && h0 >= 4'd3) hr_inc = 8'h00;
    else if (h0 == 4'd9)          hr_inc = {h1 + 4'd1, 4'd0};
    else                          hr_inc = {h1, h0 + 4'd1};
  endfunction

  function automatic logic [7:0] min_inc(input logic [3:0] m1, input logic [3:0] m0);
    if (m1 >= 4'd5 && m0 >= 4'd9) min_inc = 8'h00;
    else if (m0 == 4'd9)          min_inc = {m1 + 4'd1, 4'd0};
    else                          min_inc = {m1, m0 + 4'd1};
  endfunction

  // A simultaneous mode press swallows the inc press.
  assign w_mode_edge = mode_btn & ~r_mode_prev;
  assign w_inc_edge  = inc_btn & ~r_inc_prev & ~w_mode_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = '0;
    w_blink_cnt_nxt = '0;
    w_phase_nxt     = 1'b0;
    w_idle_nxt      = '0;
    w_edit_nxt      = r_edit;
    w_tick_nxt      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mode_edge) begin
          w_state_nxt = ST_SET_HR;
          w_edit_nxt  = {cur_h1, cur_h0, cur_m1, cur_m0};
        end else begin
          w_presc_nxt = (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
          w_tick_nxt  = (r_presc == PRESC_LAST);
        end
      end
      ST_SET_HR, ST_SET_MIN: begin
        w_idle_nxt = r_idle + 1'b1;
        if (r_blink_cnt == BLINK_LAST) begin
          w_blink_cnt_nxt = '0;
          w_phase_nxt     = ~r_phase;
        end else begin
          w_blink_cnt_nxt = r_blink_cnt + 1'b1;
          w_phase_nxt     = r_phase;
        end
        if (w_mode_edge) begin
          w_state_nxt     = (r_state == ST_SET_HR) ? ST_SET_MIN : ST_COMMIT;
          w_idle_nxt      = '0;
          w_blink_cnt_nxt = '0;
          w_phase_nxt     = 1'b0;
        end else if (w_inc_edge) begin
          w_idle_nxt      = '0;
          w_blink_cnt_nxt = '0;
          w_phase_nxt     = 1'b0;
          if (r_state == ST_SET_HR) w_edit_nxt[15:8] = hr_inc(r_edit[15:12], r_edit[11:8]);
          else                      w_edit_nxt[7:0]  = min_inc(r_edit[7:4], r_edit[3:0]);
        end else if (r_idle == IDLE_LAST) begin
          w_state_nxt     = ST_RUN;
          w_idle_nxt      = '0;
          w_blink_cnt_nxt = '0;
          w_phase_nxt     = 1'b0;
        end
      end
      ST_COMMIT: begin
        // Prescaler starts counting here so the first tick lands TICKS_PER_MIN after load.
        w_state_nxt = ST_RUN;
        w_presc_nxt = r_presc + 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_prev <= 1'b0;
      r_inc_prev  <= 1'b0;
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_idle      <= '0;
      r_edit      <= '0;
      tick        <= 1'b0;
      load        <= 1'b0;
      ld_h1       <= '0;
      ld_h0       <= '0;
      ld_m1       <= '0;
      ld_m0       <= '0;
      blank_hr    <= 1'b0;
      blank_min   <= 1'b0;
      setting     <= 1'b0;
    end else begin
      r_mode_prev <= mode_btn;
      r_inc_prev  <= inc_btn;
      r_presc     <= w_presc_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_idle      <= w_idle_nxt;
      r_edit      <= w_edit_nxt;
      tick        <= w_tick_nxt;
      load        <= (w_state_nxt == ST_COMMIT);
      if (w_state_nxt == ST_COMMIT) {ld_h1, ld_h0, ld_m1, ld_m0} <= w_edit_nxt;
      blank_hr    <= (w_state_nxt == ST_SET_HR) & w_phase_nxt;
      blank_min   <= (w_state_nxt == ST_SET_MIN) & w_phase_nxt;
      setting     <= (w_state_nxt == ST_SET_HR) | (w_state_nxt == ST_SET_MIN);
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed bench for clock_set_ctrl
// Outputs sampled 1 time unit after each rising edge; outs = {tick, load, setting, blank_hr, blank_min}.
module tb_clock_set_ctrl;

  logic       clk, rst, mode_btn, inc_btn;
  logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0;
  logic       tick, load, blank_hr, blank_min, setting;
  logic [3:0] ld_h1, ld_h0, ld_m1, ld_m0;
  logic [4:0] outs;
  int         n_tests = 0;
  int         n_fail  = 0;

  assign outs = {tick, load, setting, blank_hr, blank_min};

  clock_set_ctrl #(.TICKS_PER_MIN(4), .BLINK_DIV(2), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .tick(tick), .load(load),
    .ld_h1(ld_h1), .ld_h0(ld_h0), .ld_m1(ld_m1), .ld_m0(ld_m0),
    .blank_hr(blank_hr), .blank_min(blank_min), .setting(setting)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One button press (high one cycle, low one cycle) inside a set state.
  task automatic press_set(input bit is_mode, input string tag);
    if (is_mode) mode_btn = 1'b1;
    else         inc_btn  = 1'b1;
    step();
    check(tag, 16'(outs), 16'h0004);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    step();
    check(tag, 16'(outs), 16'h0004);
  endtask

  task automatic commit(input bit with_inc, input logic [15:0] exp_ld, input string tag);
    mode_btn = 1'b1;
    inc_btn  = with_inc;
    step();
    check({tag, "_load"}, 16'(outs), 16'h0008);
    check({tag, "_ld"}, {ld_h1, ld_h0, ld_m1, ld_m0}, exp_ld);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check({tag, "_after"}, 16'(outs), (k == 4) ? 16'h0010 : 16'h0000);
    end
  endtask

  initial begin
    logic [4:0] exp5;
    rst = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0;
    {cur_h1, cur_h0, cur_m1, cur_m0} = 16'h0000;
    step();
    step();
    check("reset_outs", 16'(outs), 16'h0000);
    check("reset_ld", {ld_h1, ld_h0, ld_m1, ld_m0}, 16'h0000);
    rst = 1'b0;

    for (int k = 1; k <= 20; k++) begin
      step();
      check("run_tick", 16'(outs), (k % 4 == 0) ? 16'h0010 : 16'h0000);
    end

    {cur_h1, cur_h0, cur_m1, cur_m0} = 16'h2258;
    press_set(1'b1, "enter_hr");
    for (int i = 0; i < 3; i++) press_set(1'b0, "inc_hr");
    press_set(1'b1, "to_min");
    for (int i = 0; i < 3; i++) press_set(1'b0, "inc_min");
    commit(1'b0, 16'h0101, "c2");

    {cur_h1, cur_h0, cur_m1, cur_m0} = 16'h2359;
    press_set(1'b1, "enter_hr3");
    press_set(1'b0, "hr_wrap");
    press_set(1'b1, "to_min3");
    press_set(1'b0, "min_wrap");
    commit(1'b0, 16'h0000, "c3");

    mode_btn = 1'b1;
    step();
    check("to_enter", 16'(outs), 16'h0004);
    mode_btn = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k < 20) exp5 = {1'b0, 1'b0, 1'b1, k[1], 1'b0};
      else        exp5 = {(k == 24), 4'b0000};
      check("timeout", 16'(outs), 16'(exp5));
    end

    {cur_h1, cur_h0, cur_m1, cur_m0} = 16'h1234;
    press_set(1'b1, "enter_hr5");
    press_set(1'b1, "to_min5");
    commit(1'b1, 16'h1234, "c5");
    for (int k = 1; k <= 8; k++) begin
      inc_btn = k[0];
      step();
      check("run_inc", 16'(outs), (k % 4 == 0) ? 16'h0010 : 16'h0000);
    end
    inc_btn = 1'b0;

    press_set(1'b1, "enter_hr6");
    press_set(1'b1, "to_min6");
    rst = 1'b1;
    #1;
    check("async_rst_outs", 16'(outs), 16'h0000);
    check("async_rst_ld", {ld_h1, ld_h0, ld_m1, ld_m0}, 16'h0000);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("post_rst", 16'(outs), (k % 4 == 0) ? 16'h0010 : 16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
